// File: rtl/qed_pkg.sv
// Shared definitions for the QED retire-side tracker: FSM encoding and default counter widths.
// Pure declarations; no timing or flow control.
package qed_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_INFL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ORIG  = 2'd1,
    DUP   = 2'd2,
    CHECK = 2'd3
  } qed_state_t;

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating up/down counter with synchronous clear; ovf/unf flag a blocked step in the current cycle.
// Count updates one cycle after inc/dec; flags are combinational; no backpressure.
module qed_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         unf
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_up;
  logic         w_dn;

  // Simultaneous inc and dec cancel, so neither limit can be hit.
  assign w_up = inc & ~dec;
  assign w_dn = dec & ~inc;
  assign ovf  = w_up & (r_cnt == '1);
  assign unf  = w_dn & (r_cnt == '0);
  assign cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (w_up && !ovf) begin
      r_cnt <= r_cnt + ONE;
    end else if (w_dn && !unf) begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/qed_commit_tracker.sv
// Retire-side QED tracker: counts issued/committed original and duplicate streams, pulses qed_ready when drained and equal.
// All outputs registered one cycle after their events; no backpressure, anomalies land on sticky cnt_err.
module qed_commit_tracker
  import qed_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int INFL_W = DEF_INFL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              exec_dup,
  input  logic              vld_out,
  input  logic              stall_IF,
  input  logic              commit_vld,
  input  logic              commit_dup,
  output logic              qed_ready,
  output logic [CNT_W-1:0]  num_orig,
  output logic [CNT_W-1:0]  num_dup,
  output logic [INFL_W-1:0] inflight,
  output logic              cnt_err
);

  qed_state_t r_state;
  qed_state_t w_state_nxt;
  logic       r_ready;
  logic       r_err;

  logic              w_issue;
  logic              w_run;
  logic              w_clr;
  logic              w_iss;
  logic              w_com;
  logic              w_c_orig;
  logic              w_c_dup;
  logic [CNT_W-1:0]  w_orig;
  logic [CNT_W-1:0]  w_dup;
  logic [INFL_W-1:0] w_infl;
  logic              w_infl_ovf;
  logic              w_infl_unf;
  logic              w_orig_ovf;
  logic              w_orig_unf;
  logic              w_dup_ovf;
  logic              w_dup_unf;
  logic              w_order_err;
  logic              w_chk_err;
  logic              w_ready_nxt;
  logic              w_err_any;

  assign w_issue  = vld_out & ~stall_IF;
  // Counters are frozen at zero in IDLE, including the cycle ena first rises.
  assign w_run    = ena & (r_state != IDLE);
  assign w_clr    = ~ena;
  assign w_iss    = w_run & w_issue;
  assign w_com    = w_run & commit_vld;
  assign w_c_orig = w_com & ~commit_dup;
  assign w_c_dup  = w_com & commit_dup;

  qed_sat_counter #(.W(INFL_W)) u_infl (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_iss),
    .dec (w_com),
    .cnt (w_infl),
    .ovf (w_infl_ovf),
    .unf (w_infl_unf)
  );

  qed_sat_counter #(.W(CNT_W)) u_orig (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_c_orig),
    .dec (1'b0),
    .cnt (w_orig),
    .ovf (w_orig_ovf),
    .unf (w_orig_unf)
  );

  qed_sat_counter #(.W(CNT_W)) u_dup (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .inc (w_c_dup),
    .dec (1'b0),
    .cnt (w_dup),
    .ovf (w_dup_ovf),
    .unf (w_dup_unf)
  );

  // A duplicate may never overtake its original stream.
  assign w_order_err = w_c_dup & (w_dup >= w_orig);

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_chk_err   = 1'b0;
    if (!ena) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = ORIG;
        ORIG:  if (w_issue && exec_dup) w_state_nxt = DUP;
        DUP:   if (!exec_dup) w_state_nxt = CHECK;
        CHECK: begin
          if ((w_infl == '0) && !commit_vld) begin
            w_state_nxt = ORIG;
            if ((w_orig == w_dup) && (w_orig != '0) && !r_err) begin
              w_ready_nxt = 1'b1;
            end else begin
              w_chk_err = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_err_any = w_infl_ovf | w_infl_unf | w_orig_ovf | w_orig_unf |
                     w_dup_ovf | w_dup_unf | w_order_err | w_chk_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      if (!ena) begin
        r_err <= 1'b0;
      end else if (w_err_any) begin
        r_err <= 1'b1;
      end
    end
  end

  assign qed_ready = r_ready;
  assign cnt_err   = r_err;
  assign num_orig  = w_orig;
  assign num_dup   = w_dup;
  assign inflight  = w_infl;

endmodule

// File: tb/tb_qed_commit_tracker.sv
// Bench for qed_commit_tracker: directed scenarios plus random traffic, all checked against a
// round-level reference model that tracks phase, stream totals and outstanding instructions.
module tb_qed_commit_tracker;

  localparam int CW   = 4;
  localparam int IW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int IMAX = (1 << IW) - 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_ORIG  = 1;
  localparam int PH_DUP   = 2;
  localparam int PH_CHECK = 3;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          ena        = 1'b0;
  logic          exec_dup   = 1'b0;
  logic          vld_out    = 1'b0;
  logic          stall_IF   = 1'b0;
  logic          commit_vld = 1'b0;
  logic          commit_dup = 1'b0;
  logic          qed_ready;
  logic [CW-1:0] num_orig;
  logic [CW-1:0] num_dup;
  logic [IW-1:0] inflight;
  logic          cnt_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_ph  = PH_IDLE;
  int m_no  = 0;
  int m_nd  = 0;
  int m_inf = 0;
  bit m_err = 1'b0;
  bit m_rdy = 1'b0;

  qed_commit_tracker #(.CNT_W(CW), .INFL_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .exec_dup   (exec_dup),
    .vld_out    (vld_out),
    .stall_IF   (stall_IF),
    .commit_vld (commit_vld),
    .commit_dup (commit_dup),
    .qed_ready  (qed_ready),
    .num_orig   (num_orig),
    .num_dup    (num_dup),
    .inflight   (inflight),
    .cnt_err    (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_no = 0; m_nd = 0; m_inf = 0; m_err = 1'b0; m_rdy = 1'b0;
  endtask

  // One clock of the reference: phase decisions use the totals as they stood before this edge.
  task automatic model_step();
    bit iss;
    bit com;
    int ph_n;
    bit err_n;
    bit rdy_n;
    iss = vld_out && !stall_IF;
    com = commit_vld;
    if (!ena) begin
      model_reset();
      return;
    end
    ph_n  = m_ph;
    err_n = m_err;
    rdy_n = 1'b0;
    case (m_ph)
      PH_IDLE: ph_n = PH_ORIG;
      PH_ORIG: if (iss && exec_dup) ph_n = PH_DUP;
      PH_DUP:  if (!exec_dup) ph_n = PH_CHECK;
      default: begin
        if (m_inf == 0 && !com) begin
          ph_n = PH_ORIG;
          if (m_no == m_nd && m_no != 0 && !m_err) rdy_n = 1'b1;
          else err_n = 1'b1;
        end
      end
    endcase
    if (m_ph != PH_IDLE) begin
      if (iss && !com) begin
        if (m_inf == IMAX) err_n = 1'b1; else m_inf++;
      end
      if (com && !iss) begin
        if (m_inf == 0) err_n = 1'b1; else m_inf--;
      end
      if (com && commit_dup) begin
        if (m_nd + 1 > m_no) err_n = 1'b1;
        if (m_nd == CMAX) err_n = 1'b1; else m_nd++;
      end else if (com) begin
        if (m_no == CMAX) err_n = 1'b1; else m_no++;
      end
    end
    m_ph  = ph_n;
    m_err = err_n;
    m_rdy = rdy_n;
  endtask

  task automatic cmp_all();
    chk("qed_ready", 32'(qed_ready), 32'(m_rdy));
    chk("num_orig",  32'(num_orig),  32'(m_no));
    chk("num_dup",   32'(num_dup),   32'(m_nd));
    chk("inflight",  32'(inflight),  32'(m_inf));
    chk("cnt_err",   32'(cnt_err),   32'(m_err));
  endtask

  task automatic step(input bit e, input bit x, input bit v, input bit s, input bit cv, input bit cd);
    ena = e; exec_dup = x; vld_out = v; stall_IF = s; commit_vld = cv; commit_dup = cd;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    cmp_all();
  endtask

  bit rx;

  initial begin
    #1;
    chk("rst_rdy",  32'(qed_ready), 32'd0);
    chk("rst_orig", 32'(num_orig),  32'd0);
    chk("rst_dup",  32'(num_dup),   32'd0);
    chk("rst_infl", 32'(inflight),  32'd0);
    chk("rst_err",  32'(cnt_err),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic round: 3 originals, a stall, 3 duplicates, then commit all six.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, (i >= 3));
    chk("basic_infl0", 32'(inflight), 32'd0);
    chk("basic_rdy_early", 32'(qed_ready), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("basic_rdy", 32'(qed_ready), 32'd1);
    chk("basic_orig", 32'(num_orig), 32'd3);
    chk("basic_dup", 32'(num_dup), 32'd3);
    chk("basic_err", 32'(cnt_err), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("basic_pulse_end", 32'(qed_ready), 32'd0);

    // Mismatch round: one duplicate short, counts carried over from the first round.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, (i >= 3));
    step(1, 0, 0, 0, 0, 0);
    chk("mism_err", 32'(cnt_err), 32'd1);
    chk("mism_rdy", 32'(qed_ready), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("mism_rdy2", 32'(qed_ready), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("ena_clr_err", 32'(cnt_err), 32'd0);
    chk("ena_clr_orig", 32'(num_orig), 32'd0);

    // Simultaneous issue and commit with two outstanding.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 0, 1, (i % 2 == 1));
      chk("sim_infl", 32'(inflight), 32'd2);
    end
    chk("sim_total", 32'(num_orig) + 32'(num_dup), 32'd8);
    chk("sim_err", 32'(cnt_err), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Underflow, then ordering error on a fresh round.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("unf_err", 32'(cnt_err), 32'd1);
    chk("unf_infl", 32'(inflight), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("ord_pre_err", 32'(cnt_err), 32'd0);
    step(1, 0, 0, 0, 1, 1);
    chk("ord_err", 32'(cnt_err), 32'd1);
    chk("ord_dup", 32'(num_dup), 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // Commit-counter saturation at CMAX.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CMAX; i++) step(1, 0, 1, 0, 1, 0);
    chk("sat_pre_orig", 32'(num_orig), 32'(CMAX));
    chk("sat_pre_err", 32'(cnt_err), 32'd0);
    step(1, 0, 1, 0, 1, 0);
    chk("sat_orig", 32'(num_orig), 32'(CMAX));
    chk("sat_err", 32'(cnt_err), 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset while in the duplicate phase with three outstanding.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("pre_rst_infl", 32'(inflight), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_rdy",  32'(qed_ready), 32'd0);
    chk("arst_orig", 32'(num_orig),  32'd0);
    chk("arst_dup",  32'(num_dup),   32'd0);
    chk("arst_infl", 32'(inflight),  32'd0);
    chk("arst_err",  32'(cnt_err),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("orig_err_set", 32'(cnt_err), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_err",  32'(cnt_err),  32'd0);
    chk("drop_orig", 32'(num_orig), 32'd0);
    chk("drop_infl", 32'(inflight), 32'd0);

    // Random traffic.
    rx = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) rx = ~rx;
      step(($urandom_range(0, 39) != 0), rx,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/qed_commit_tracker.md
Name: qed_commit_tracker

Overview:
- Sits downstream of the qed fetch-side block (decoder, modify, mux, i-cache), on the retire side of the core.
- Counts issued and committed original and duplicate instructions, and tracks how many are in flight.
- Asserts a one-cycle qed_ready when both streams have fully drained and their commit counts are equal. That is the trigger for the external register-file consistency check.
- Flags counter overflow, underflow and stream-ordering errors with a sticky error bit.

Parameters:
- CNT_W, 16, width of the original and duplicate commit counters.
- INFL_W, 4, width of the in-flight counter; sized so it covers pipeline depth + 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low.
- ena  in  1  QED mode enable; same signal that drives the qed block.
- exec_dup  in  1  fetch is in duplicate phase; same signal that drives the qed block.
- vld_out  in  1  qed block is presenting a valid instruction.
- stall_IF  in  1  fetch stall; issue event = vld_out & ~stall_IF.
- commit_vld  in  1  one instruction retires this cycle.
- commit_dup  in  1  tag of the retiring instruction: 1 = duplicate, 0 = original.
- qed_ready  out  1  one-cycle pulse; streams drained and equal.
- num_orig  out  CNT_W  committed original instruction count.
- num_dup  out  CNT_W  committed duplicate instruction count.
- inflight  out  INFL_W  number of issued but not yet committed instructions.
- cnt_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; qed_ready=0; num_orig=0; num_dup=0; inflight=0; cnt_err=0.
- All outputs are registered. Each output reflects its input events one cycle later.
- inflight counter:
  - issue only: +1.
  - commit only: -1.
  - issue and commit in the same cycle: unchanged.
  - commit while inflight=0: inflight stays 0 and cnt_err is set.
  - issue while inflight is all ones: inflight holds and cnt_err is set.
- Commit counters:
  - commit_vld with commit_dup=0 increments num_orig; with commit_dup=1 increments num_dup.
  - A counter at its maximum value saturates and sets cnt_err.
  - If a duplicate commit would make num_dup > num_orig, the increment still happens and cnt_err is set.
- Counters are cumulative across rounds. They clear only on reset or when ena falls.
- FSM states: IDLE, ORIG, DUP, CHECK.
  - IDLE: all counters held at 0. Go to ORIG when ena=1.
  - ORIG: go to DUP on an issue event with exec_dup=1.
  - DUP: go to CHECK on the first cycle with exec_dup=0.
  - CHECK: wait until inflight=0 and no commit_vld is pending this cycle.
    - If num_orig==num_dup and num_orig!=0: qed_ready=1 for exactly one cycle, then go to ORIG.
    - Otherwise: set cnt_err, keep qed_ready=0, go to ORIG.
    - Issue events during CHECK are legal. They delay the drain (inflight ≠ 0) and do not change the state.
- ena=0 in any state:
  - Next cycle: state=IDLE, counters cleared, cnt_err cleared, qed_ready=0.
  - Commits in that cycle are ignored.
- cnt_err stays set until reset or ena falls.
- qed_ready is never asserted in IDLE, ORIG or DUP, and never in a cycle where cnt_err is already set.

Decomposition:
- Shared package qed_pkg holds:
  - state encoding localparams: IDLE=2'd0, ORIG=2'd1, DUP=2'd2, CHECK=2'd3.
  - CNT_W and INFL_W defaults.
- One sub-module: qed_sat_counter. It is a parameterised-width up/down counter with saturate and underflow/overflow flag outputs. It is used three times: num_orig, num_dup and inflight.

Test Plan:
- Basic round: reset, ena=1. Issue 3 originals (exec_dup=0), then 3 duplicates (exec_dup=1), drop exec_dup, commit all 6 (tags 0,0,0,1,1,1).
  - Required: qed_ready pulses exactly 1 cycle after inflight reaches 0; num_orig=num_dup=3; cnt_err=0.
- Mismatch: 3 originals committed, only 2 duplicates committed, inflight drained.
  - Required: in CHECK, cnt_err=1 and qed_ready never asserts; state then goes to ORIG.
- Simultaneous issue and commit every cycle for 8 cycles, starting with inflight=2.
  - Required: inflight stays 2 throughout; num counters advance by 8 in total.
- Underflow and order error:
  - commit_vld with inflight=0 → cnt_err=1, inflight stays 0.
  - Separately, a duplicate commit with num_orig=0 → cnt_err=1.
- Saturation: CNT_W=4, commit 16 originals.
  - Required: num_orig holds at 15 and cnt_err=1 on the 16th commit.
- Reset mid-operation: rst=0 asynchronously while in DUP with inflight=3.
  - Required: all outputs 0 immediately, state IDLE.
  - Then ena toggled 1→0 while in ORIG → counters and cnt_err cleared the next cycle.
